// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Bundles the serial input and the parallel-side outputs of the UART receiver.
//   Signals:
//     rx         serial line into the receiver (idles high)
//     data[7:0]  last correctly received byte
//     rcv        1-cycle strobe: data updated this cycle
//     ferr       1-cycle strobe: framing error, data not updated
//     busy       receiver is inside a frame (not IDLE)
//     state_dbg  current receiver FSM state encoding, for observation only
//   Modports:
//     master  the receiver (drives data/strobes, consumes rx)
//     slave   the environment (drives rx, consumes data/strobes)
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic       busy;
    logic [2:0] state_dbg;

    modport master (
        input  rx,
        output data, rcv, ferr, busy, state_dbg
    );

    modport slave (
        output rx,
        input  data, rcv, ferr, busy, state_dbg
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx
//   8N1 UART receiver, LSB first. The rx pin is brought into the clk domain
//   through a 2-FF synchroniser; a falling edge in IDLE starts a frame, each
//   bit is sampled at mid-period using a clock-cycle counter.
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   uart_rx_if.master (rx in; data, rcv, ferr, busy, state_dbg out)
//   Output protocol: there is no back-pressure. rcv pulses for exactly one
//   cycle when data takes a new byte; ferr pulses for exactly one cycle when a
//   stop bit is sampled low, and data is left unchanged. The two strobes are
//   never high together, and neither is high on two consecutive cycles.
module uart_rx #(
    parameter int BAUD_DIV = 104,
    parameter int CW       = 7
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_t;

    localparam logic [CW-1:0] HALF_T = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_T = CW'(BAUD_DIV - 1);

    state_t        state, state_nxt;
    logic          rx_m, rx_s, rx_p;
    logic [CW-1:0] cnt;
    logic [CW-1:0] target;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    data_q;
    logic          rcv_q, ferr_q;

    logic          tick, fall;
    logic          do_shift, do_rcv, do_ferr;

    // Synchroniser plus one history stage for edge detection. All reset to
    // the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    assign fall   = rx_p & ~rx_s;
    // START waits half a bit to land mid start bit; afterwards whole bits.
    assign target = (state == S_START) ? HALF_T : FULL_T;
    assign tick   = (cnt == target);

    always_comb begin
        state_nxt = state;
        do_shift  = 1'b0;
        do_rcv    = 1'b0;
        do_ferr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) state_nxt = S_START;
            end
            S_START: begin
                if (tick) begin
                    // A high line at mid start bit was only a glitch.
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    do_shift = 1'b1;
                    if (bit_idx == 3'd7) state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        do_rcv    = 1'b1;
                        // Leaving mid stop bit lets the next start edge be seen.
                        state_nxt = S_IDLE;
                    end else begin
                        do_ferr   = 1'b1;
                        state_nxt = S_BRK;
                    end
                end
            end
            S_BRK: begin
                // Line held low (break): wait for it to return to idle.
                if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit-period counter: restarts on every state change and every sample,
    // and stays parked at zero while waiting for an edge or for the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nxt != state || tick ||
                     state == S_IDLE || state == S_BRK) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if (state != S_DATA) begin
                bit_idx <= 3'd0;
            end else if (do_shift) begin
                bit_idx <= bit_idx + 3'd1;
            end
            // LSB arrives first, so bits enter at the top and move down.
            if (do_shift) begin
                shreg <= {rx_s, shreg[7:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= 8'h00;
            rcv_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            rcv_q  <= do_rcv;
            ferr_q <= do_ferr;
            if (do_rcv) begin
                data_q <= shreg;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.rcv       = rcv_q;
    assign bus.ferr      = ferr_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.state_dbg = state;

endmodule
